cga_mode_init_master: RTL and testbench

- ISA I/O-cycle initiator that programs the CGA core to one of four standard modes after reset or on request.
- Replays a fixed register table as ISA IOW cycles: mode-control (3D8), CRTC index/data pairs (3D4/3D5, R0–R9) and color-select (3D9).
- Optionally polls status (3DA) for vertical retrace first, so reprogramming does not tear the displayed frame.
- Sits between the system's boot/OSD control logic and the CGA core's bus_a/bus_d/bus_iow_l/bus_ior_l/bus_aen inputs.

---
 rtl/cga_init_pkg.sv | 68 ++++++
 rtl/isa_io_cycle.sv | 128 ++++++++++++
 rtl/cga_mode_init_master.sv | 203 ++++++++++++++++++++
 tb/tb_cga_mode_init_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_init_pkg.sv
// Shared definitions for the CGA mode-init master.
// Contents: FSM state encodings for the sequencer and the ISA cycle engine,
// mode_sel encodings, CGA register offsets within the I/O window and the
// four 12-entry register tables (R0..R9, mode_ctrl, color) with a lookup
// helper.
package cga_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_POLL_WAIT,
        ST_POLL_CHECK,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } init_state_e;

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_SETUP,
        IO_STROBE,
        IO_HOLD
    } io_state_e;

    typedef enum logic [1:0] {
        MODE_TEXT_40X25  = 2'd0,
        MODE_TEXT_80X25  = 2'd1,
        MODE_GFX_320X200 = 2'd2,
        MODE_GFX_640X200 = 2'd3
    } cga_mode_e;

    // Register offsets from the I/O window base
    localparam logic [3:0] REG_CRTC_INDEX = 4'h4;
    localparam logic [3:0] REG_CRTC_DATA  = 4'h5;
    localparam logic [3:0] REG_MODE_CTRL  = 4'h8;
    localparam logic [3:0] REG_COLOR_SEL  = 4'h9;
    localparam logic [3:0] REG_STATUS     = 4'hA;

    // Table slots after the ten CRTC values
    localparam logic [3:0] TBL_MODE_CTRL = 4'd10;
    localparam logic [3:0] TBL_COLOR     = 4'd11;

    localparam logic [7:0] STATUS_VRETRACE_MASK = 8'h08;
    localparam logic [7:0] MODE_CTRL_VIDEO_EN   = 8'h08;
    localparam logic [4:0] LAST_STEP            = 5'd22;

    // Entry 0 (R0) sits in the most significant byte
    localparam logic [95:0] TABLE_MODE0 = {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06,
                                           8'h19, 8'h1C, 8'h02, 8'h07, 8'h28, 8'h00};
    localparam logic [95:0] TABLE_MODE1 = {8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06,
                                           8'h19, 8'h1C, 8'h02, 8'h07, 8'h29, 8'h00};
    localparam logic [95:0] TABLE_MODE2 = {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06,
                                           8'h64, 8'h70, 8'h02, 8'h01, 8'h2A, 8'h30};
    localparam logic [95:0] TABLE_MODE3 = {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06,
                                           8'h64, 8'h70, 8'h02, 8'h01, 8'h1E, 8'h3F};

    function automatic logic [7:0] table_value(input cga_mode_e mode, input logic [3:0] idx);
        logic [95:0] row;
        case (mode)
            MODE_TEXT_40X25:  row = TABLE_MODE0;
            MODE_TEXT_80X25:  row = TABLE_MODE1;
            MODE_GFX_320X200: row = TABLE_MODE2;
            default:          row = TABLE_MODE3;
        endcase
        return row[7'd95 - {idx, 3'b000} -: 8];
    endfunction

endpackage

// File: rtl/isa_io_cycle.sv
// Single ISA I/O cycle engine.
// A one-cycle req in IO_IDLE captures addr/wdata/wr and runs:
//   SETUP  (1 cycle)        : address valid, aen low, strobes high
//   STROBE (STROBE_CYCLES)  : iow_l or ior_l low; bus_din captured on the last cycle
//   HOLD   (HOLD_CYCLES)    : strobes high, address/data unchanged
// ack pulses on the last HOLD cycle; the bus then returns to idle
// (aen high, address/data zero).
// Ports: clk, reset (async, active high); req, wr, addr, wdata -> ack, rdata;
//        bus_a, bus_d, bus_iow_l, bus_ior_l, bus_aen to the CGA core, bus_din from it.
module isa_io_cycle #(
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [14:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d,
    input  logic [7:0]  bus_din,
    output logic        bus_iow_l,
    output logic        bus_ior_l,
    output logic        bus_aen
);
    import cga_init_pkg::*;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

    io_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [14:0] a_q, a_d;
    logic [7:0]  d_q, d_d;
    logic        iow_q, iow_d;
    logic        ior_q, ior_d;
    logic        aen_q, aen_d;
    logic [7:0]  rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        a_d     = a_q;
        d_d     = d_q;
        iow_d   = iow_q;
        ior_d   = ior_q;
        aen_d   = aen_q;
        rdata_d = rdata_q;
        case (state_q)
            IO_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    a_d     = addr;
                    d_d     = wr ? wdata : 8'h00;
                    aen_d   = 1'b0;
                    state_d = IO_SETUP;
                end
            end
            IO_SETUP: begin
                // Only one strobe is ever driven low, chosen by direction
                if (wr_q) iow_d = 1'b0;
                else      ior_d = 1'b0;
                cnt_d   = 4'd0;
                state_d = IO_STROBE;
            end
            IO_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    iow_d   = 1'b1;
                    ior_d   = 1'b1;
                    if (!wr_q) rdata_d = bus_din;
                    cnt_d   = 4'd0;
                    state_d = IO_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IO_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    a_d     = 15'd0;
                    d_d     = 8'h00;
                    aen_d   = 1'b1;
                    state_d = IO_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IO_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IO_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            a_q     <= 15'd0;
            d_q     <= 8'h00;
            iow_q   <= 1'b1;
            ior_q   <= 1'b1;
            aen_q   <= 1'b1;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            d_q     <= d_d;
            iow_q   <= iow_d;
            ior_q   <= ior_d;
            aen_q   <= aen_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack       = (state_q == IO_HOLD) && (cnt_q == HOLD_LAST);
    assign rdata     = rdata_q;
    assign bus_a     = a_q;
    assign bus_d     = d_q;
    assign bus_iow_l = iow_q;
    assign bus_ior_l = ior_q;
    assign bus_aen   = aen_q;

endmodule

// File: rtl/cga_mode_init_master.sv
// CGA mode-init master: replays one of four register tables into the CGA
// core as 23 ISA IOW cycles, optionally after waiting for vertical retrace.
// Ports: clk, reset (async, active high); start, mode_sel from control logic;
//        busy, done (pulse), timeout (sticky) status; bus_a, bus_d, bus_iow_l,
//        bus_ior_l, bus_aen to the CGA core; bus_din read data from the core.
// Write steps: 0 mode_ctrl with video off, 1..20 CRTC index/data pairs,
// 21 color select, 22 mode_ctrl with video on.
module cga_mode_init_master #(
    parameter logic [15:0] IO_BASE_ADDR  = 16'h03d0,
    parameter int          STROBE_CYCLES = 4,
    parameter int          HOLD_CYCLES   = 2,
    parameter bit          WAIT_VRETRACE = 1'b1,
    parameter logic [19:0] POLL_TIMEOUT  = 20'd600000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode_sel,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d,
    input  logic [7:0]  bus_din,
    output logic        bus_iow_l,
    output logic        bus_ior_l,
    output logic        bus_aen
);
    import cga_init_pkg::*;

    localparam logic [14:0] BASE_A = IO_BASE_ADDR[14:0];

    init_state_e state_q, state_d;
    logic [4:0]  step_q, step_d;
    cga_mode_e   mode_q, mode_d;
    logic [19:0] poll_cnt_q, poll_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic        io_req, io_wr, io_ack;
    logic [14:0] io_addr;
    logic [7:0]  io_wdata, io_rdata;

    cga_mode_e   tbl_mode;
    logic [3:0]  crtc_idx;
    logic [7:0]  mode_ctrl;
    logic [3:0]  wr_off;
    logic [7:0]  wr_data;
    logic        poll_hit;
    logic        vretrace;

    // Table lookup for the current step. In IDLE the live mode_sel is used so
    // step 0 can be issued in the same cycle start is accepted, keeping the
    // whole sequence at exactly 23 x (2 + STROBE + HOLD) cycles.
    always_comb begin
        tbl_mode  = (state_q == ST_IDLE) ? cga_mode_e'(mode_sel) : mode_q;
        crtc_idx  = 4'((step_q - 5'd1) >> 1);
        mode_ctrl = table_value(tbl_mode, TBL_MODE_CTRL);
        wr_off    = REG_MODE_CTRL;
        wr_data   = mode_ctrl;
        if (step_q == 5'd0) begin
            wr_data = mode_ctrl & ~MODE_CTRL_VIDEO_EN;
        end else if (step_q <= 5'd20) begin
            if (step_q[0]) begin
                wr_off  = REG_CRTC_INDEX;
                wr_data = {4'h0, crtc_idx};
            end else begin
                wr_off  = REG_CRTC_DATA;
                wr_data = table_value(tbl_mode, crtc_idx);
            end
        end else if (step_q == 5'd21) begin
            wr_off  = REG_COLOR_SEL;
            wr_data = table_value(tbl_mode, TBL_COLOR);
        end
    end

    assign poll_hit = (poll_cnt_q == POLL_TIMEOUT - 20'd1);
    assign vretrace = |(io_rdata & STATUS_VRETRACE_MASK);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        mode_d     = mode_q;
        poll_cnt_d = poll_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = timeout_q;
        io_req     = 1'b0;
        io_wr      = 1'b1;
        io_addr    = BASE_A + {11'd0, wr_off};
        io_wdata   = wr_data;

        // Poll cycle budget; stops counting once the timeout has fired
        if ((state_q == ST_POLL || state_q == ST_POLL_WAIT || state_q == ST_POLL_CHECK)
            && !timeout_q) begin
            poll_cnt_d = poll_cnt_q + 20'd1;
            if (poll_hit) timeout_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = cga_mode_e'(mode_sel);
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    step_d     = 5'd0;
                    poll_cnt_d = 20'd0;
                    if (WAIT_VRETRACE) begin
                        state_d = ST_POLL;
                    end else begin
                        io_req  = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_POLL: begin
                if (timeout_q || poll_hit) begin
                    state_d = ST_LOAD;
                end else begin
                    io_req  = 1'b1;
                    io_wr   = 1'b0;
                    io_addr = BASE_A + {11'd0, REG_STATUS};
                    state_d = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                // A read in flight always completes so the bus never sees a cut strobe
                if (io_ack) state_d = ST_POLL_CHECK;
            end
            ST_POLL_CHECK: begin
                if (vretrace || timeout_q || poll_hit) state_d = ST_LOAD;
                else                                   state_d = ST_POLL;
            end
            ST_LOAD: begin
                io_req  = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (io_ack) begin
                    if (step_q == LAST_STEP) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + 5'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                step_d  = 5'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= 5'd0;
            mode_q     <= MODE_TEXT_40X25;
            poll_cnt_q <= 20'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            mode_q     <= mode_d;
            poll_cnt_q <= poll_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    isa_io_cycle #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_io (
        .clk       (clk),
        .reset     (reset),
        .req       (io_req),
        .wr        (io_wr),
        .addr      (io_addr),
        .wdata     (io_wdata),
        .ack       (io_ack),
        .rdata     (io_rdata),
        .bus_a     (bus_a),
        .bus_d     (bus_d),
        .bus_din   (bus_din),
        .bus_iow_l (bus_iow_l),
        .bus_ior_l (bus_ior_l),
        .bus_aen   (bus_aen)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_cga_mode_init_master.sv
// Bench for cga_mode_init_master: one instance without retrace wait, one
// with retrace polling and a short poll timeout.
module tb_cga_mode_init_master;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [1:0]        mode;
        logic [0:11][7:0]  vals;       // R0..R9, mode_ctrl, color
        int                glitch_at;  // cycle of an extra start pulse, 0 = none
        int                done_cycle;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start   [2];
    logic [1:0]  mode    [2];
    logic        busy    [2];
    logic        done    [2];
    logic        timeout [2];
    logic [14:0] bus_a   [2];
    logic [7:0]  bus_d   [2];
    logic [7:0]  din     [2];
    logic        iow     [2];
    logic        ior     [2];
    logic        aen     [2];

    int checks = 0;
    int errors = 0;

    wr_t wq0[$];
    wr_t wq1[$];
    int  proto_err  [2];
    int  ior_pulses [2];
    int  low_cnt    [2];
    logic        prev_iow [2];
    logic        prev_ior [2];
    logic [14:0] prev_a   [2];
    int  early_iow = 0;
    bit  stuck = 1'b0;

    vec_t vec[7];
    logic [0:11][7:0] ref_tbl [4];

    always #5 clk = ~clk;

    cga_mode_init_master #(
        .WAIT_VRETRACE (1'b0)
    ) u_dut_nowait (
        .clk(clk), .reset(reset), .start(start[0]), .mode_sel(mode[0]),
        .busy(busy[0]), .done(done[0]), .timeout(timeout[0]),
        .bus_a(bus_a[0]), .bus_d(bus_d[0]), .bus_din(din[0]),
        .bus_iow_l(iow[0]), .bus_ior_l(ior[0]), .bus_aen(aen[0])
    );

    cga_mode_init_master #(
        .WAIT_VRETRACE (1'b1),
        .POLL_TIMEOUT  (20'd600)
    ) u_dut_wait (
        .clk(clk), .reset(reset), .start(start[1]), .mode_sel(mode[1]),
        .busy(busy[1]), .done(done[1]), .timeout(timeout[1]),
        .bus_a(bus_a[1]), .bus_d(bus_d[1]), .bus_din(din[1]),
        .bus_iow_l(iow[1]), .bus_ior_l(ior[1]), .bus_aen(aen[1])
    );

    // Bus monitor: captures IOW transactions, counts IOR pulses, checks protocol
    // and supplies status data (bit 3 rises after 50 status reads unless stuck).
    initial begin
        for (int k = 0; k < 2; k++) begin
            proto_err[k] = 0; ior_pulses[k] = 0; low_cnt[k] = 0;
            prev_iow[k] = 1'b1; prev_ior[k] = 1'b1; prev_a[k] = 15'd0;
            din[k] = 8'h00;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                if (!iow[k] && !ior[k]) proto_err[k]++;
                if ((bus_a[k] != prev_a[k]) &&
                    !(iow[k] && ior[k] && prev_iow[k] && prev_ior[k])) proto_err[k]++;
                if (!iow[k] || !ior[k]) begin
                    low_cnt[k]++;
                    if (aen[k]) proto_err[k]++;
                end else if (!prev_iow[k] || !prev_ior[k]) begin
                    if (low_cnt[k] != 4) proto_err[k]++;
                    low_cnt[k] = 0;
                end
                if (!iow[k] && prev_iow[k]) begin
                    if (k == 0) wq0.push_back(wr_t'({bus_a[0], bus_d[0]}));
                    else begin
                        wq1.push_back(wr_t'({bus_a[1], bus_d[1]}));
                        if (!stuck && ior_pulses[1] <= 50) early_iow++;
                    end
                end
                if (!ior[k] && prev_ior[k]) ior_pulses[k]++;
            end else begin
                low_cnt[k] = 0;
            end
            prev_iow[k] = iow[k];
            prev_ior[k] = ior[k];
            prev_a[k]   = bus_a[k];
            din[k] = 8'($urandom) & 8'hF7;
            if (k == 1 && !stuck && ior_pulses[1] > 50) din[k] = din[k] | 8'h08;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: the 23 writes a mode programs, built from the register list.
    task automatic check_writes(input int k, input logic [1:0] m, input string tag);
        wr_t exp_q[$];
        wr_t got;
        int  n;
        exp_q.push_back(wr_t'({15'h3D8, ref_tbl[m][10] & 8'hF7}));
        for (int r = 0; r < 10; r++) begin
            exp_q.push_back(wr_t'({15'h3D4, 8'(r)}));
            exp_q.push_back(wr_t'({15'h3D5, ref_tbl[m][r]}));
        end
        exp_q.push_back(wr_t'({15'h3D9, ref_tbl[m][11]}));
        exp_q.push_back(wr_t'({15'h3D8, ref_tbl[m][10]}));
        n = (k == 0) ? wq0.size() : wq1.size();
        check({tag, "_write_count"}, 32'(n), 32'd23);
        for (int i = 0; i < 23 && i < n; i++) begin
            got = (k == 0) ? wq0[i] : wq1[i];
            check($sformatf("%s_w%0d", tag, i), 32'(got), 32'(exp_q[i]));
        end
    endtask

    task automatic run_nowait(input logic [1:0] m, input int glitch_at, input int exp_done,
                              input string tag);
        int n, busy_gap, pe, post_busy;
        wq0.delete();
        pe = proto_err[0];
        busy_gap = 0;
        post_busy = 0;
        start[0] = 1'b1; mode[0] = m;
        tick();
        start[0] = 1'b0;
        n = 1;
        check({tag, "_busy_start"}, 32'(busy[0]), 32'd1);
        while (!done[0] && n < 400) begin
            if (!busy[0]) busy_gap++;
            if (n == glitch_at) begin start[0] = 1'b1; mode[0] = ~m; end
            tick();
            start[0] = 1'b0;
            n++;
        end
        check({tag, "_done_cycle"}, 32'(n), 32'(exp_done));
        check({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
        check({tag, "_done_bus"}, {busy[0], aen[0], iow[0], ior[0], 5'd0, bus_a[0], bus_d[0]},
              {1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 15'd0, 8'd0});
        // A start during the DONE cycle must be ignored as well
        if (glitch_at == n) begin start[0] = 1'b1; mode[0] = ~m; end
        tick();
        start[0] = 1'b0;
        check({tag, "_done_pulse"}, 32'(done[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (busy[0]) post_busy++;
            tick();
        end
        check({tag, "_post_idle"}, 32'(post_busy), 32'd0);
        check({tag, "_timeout"}, 32'(timeout[0]), 32'd0);
        check_writes(0, m, tag);
        check({tag, "_protocol"}, 32'(proto_err[0] - pe), 32'd0);
        $display("run %s mode=%0d writes=%0d done_cycle=%0d", tag, m, wq0.size(), n);
    endtask

    task automatic run_wait(input logic [1:0] m, input bit stuck_in, input string tag);
        int n, tcyc, pe;
        wq1.delete();
        stuck = stuck_in;
        ior_pulses[1] = 0;
        early_iow = 0;
        pe = proto_err[1];
        tcyc = 0;
        start[1] = 1'b1; mode[1] = m;
        tick();
        start[1] = 1'b0;
        n = 1;
        check({tag, "_timeout_clear"}, 32'(timeout[1]), 32'd0);
        while (!done[1] && n < 2000) begin
            if (timeout[1] && tcyc == 0) tcyc = n;
            if (n == 100) begin start[1] = 1'b1; mode[1] = ~m; end
            tick();
            start[1] = 1'b0;
            n++;
        end
        check({tag, "_done_seen"}, 32'(done[1]), 32'd1);
        if (stuck_in) begin
            check({tag, "_timeout_set"}, 32'(timeout[1]), 32'd1);
            check({tag, "_timeout_cycle"}, 32'(tcyc), 32'd601);
        end else begin
            check({tag, "_timeout_set"}, 32'(timeout[1]), 32'd0);
            check({tag, "_poll_reads"}, 32'(ior_pulses[1]), 32'd51);
            check({tag, "_early_iow"}, 32'(early_iow), 32'd0);
        end
        check_writes(1, m, tag);
        check({tag, "_protocol"}, 32'(proto_err[1] - pe), 32'd0);
        tick();
        $display("run %s mode=%0d writes=%0d polls=%0d done_cycle=%0d", tag, m, wq1.size(),
                 ior_pulses[1], n);
    endtask

    initial begin
        int n;
        logic [1:0] m;
        vec[0] = '{mode: 2'd0, vals: {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                   8'h02, 8'h07, 8'h28, 8'h00}, glitch_at: 0, done_cycle: 184};
        vec[1] = '{mode: 2'd1, vals: {8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
                   8'h02, 8'h07, 8'h29, 8'h00}, glitch_at: 0, done_cycle: 184};
        vec[2] = '{mode: 2'd2, vals: {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
                   8'h02, 8'h01, 8'h2A, 8'h30}, glitch_at: 0, done_cycle: 184};
        vec[3] = '{mode: 2'd3, vals: {8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
                   8'h02, 8'h01, 8'h1E, 8'h3F}, glitch_at: 0, done_cycle: 184};
        vec[4] = vec[1]; vec[4].glitch_at = 30;
        vec[5] = vec[3]; vec[5].glitch_at = 183;
        vec[6] = vec[2]; vec[6].glitch_at = 184;
        for (int i = 0; i < 7; i++) ref_tbl[vec[i].mode] = vec[i].vals;

        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin start[k] = 1'b0; mode[k] = 2'd0; end
        tick(); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_flags%0d", k),
                  {26'd0, busy[k], done[k], timeout[k], iow[k], ior[k], aen[k]}, 32'b000111);
            check($sformatf("reset_bus%0d", k), {9'd0, bus_a[k], bus_d[k]}, 32'd0);
        end
        reset = 1'b0;
        tick(); tick();

        for (int i = 0; i < 7; i++)
            run_nowait(vec[i].mode, vec[i].glitch_at, vec[i].done_cycle, $sformatf("vec%0d", i));

        for (int r = 0; r < 6; r++) begin
            m = 2'($urandom_range(3));
            run_nowait(m, $urandom_range(184, 1), 184, $sformatf("rand%0d", r));
        end

        // Reset during the strobe of step 10, then a clean replay from step 0
        start[0] = 1'b1; mode[0] = 2'd1;
        tick();
        start[0] = 1'b0;
        wq0.delete();
        n = 0;
        while (wq0.size() < 11 && n < 300) begin tick(); n++; end
        check("rst_mid_reached", 32'(wq0.size()), 32'd11);
        reset = 1'b1;
        #1;
        check("rst_mid_release", {29'd0, iow[0], aen[0], busy[0]}, 32'b110);
        tick(); tick();
        reset = 1'b0;
        tick();
        run_nowait(2'd1, 0, 184, "after_reset");

        run_wait(2'($urandom_range(3)), 1'b1, "poll_stuck");
        run_wait(2'($urandom_range(3)), 1'b0, "poll_50");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
